alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
Two-requester front end for the shared ALU. It arbitrates round-robin between requester 0 (instruction execution) and requester 1 (address/effective-address unit). It latches the winner's command and operands, drives the ALU and holds the command while the ALU reports busy for multi-cycle ops such as shifts. It captures results and flags, returns them with a one-cycle done pulse, and aborts with an error if busy never clears.

Parameters:
width, 36, data word width (PDP-10 word)
TIMEOUT, 300, max cycles in WAIT before abort; must exceed longest multi-cycle ALU op

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (asserted when 0)
req0  in  1  requester 0 request; held until ack0
cmd0  in  `aluCMDwidth  requester 0 ALU command
op1high0  in  width  requester 0 high word of doubleword op1
op1_0  in  width  requester 0 first operand
op2_0  in  width  requester 0 second operand
ack0  out  1  one-cycle pulse: request 0 accepted, operands latched
req1, cmd1, op1high1, op1_1, op2_1, ack1  -  same as requester 0, for requester 1
done  out  1  one-cycle pulse: results valid this cycle
done_id  out  1  requester that owns the completing op
err  out  1  with done: op aborted by timeout, results invalid
res_high, res_low  out  width  captured resulthigh/resultlow
res_ovf, res_cry0, res_cry1, res_zero  out  1  captured overflow, carry0, carry1, zero
alu_command  out  `aluCMDwidth  to ALU command
alu_op1high, alu_op1, alu_op2  out  width  to ALU operands
alu_resulthigh, alu_resultlow  in  width  from ALU
alu_overflow, alu_carry0, alu_carry1, alu_zero, alu_busy  in  1  from ALU

Behaviour:
- Reset (reset=0, async): state IDLE; alu_command=`aluOFF; operand outputs, res_*, done, done_id, err, ack0, ack1 all 0; round-robin pointer favours requester 0.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: if any req is high, choose the winner. With both requests high, the requester not granted last wins. Latch cmd/op1high/op1/op2 and the winner id, pulse that ack, update the pointer, go to ISSUE. With no request, stay in IDLE with alu_command=`aluOFF.
- ISSUE: drive alu_command and operands from the latches; clear the timeout counter; go to WAIT.
- WAIT: keep driving the same command and operands every cycle.
  - alu_busy=0: capture all results and flags, go to DONE.
  - alu_busy=1: increment the counter.
  - Counter reaches TIMEOUT: go to DONE with err=1 and res_* zeroed.
- DONE: pulse done for one cycle with done_id and err; alu_command=`aluOFF; go to IDLE.
- Latency: request seen in IDLE at cycle N gives ack at N+1, done at N+4 for a single-cycle op, plus one cycle per extra busy cycle.
- Throughput: one op per 4+ cycles. A requester may re-request in the cycle after ack; it is served no earlier than the IDLE following DONE.
- Requester contract: cmd and operands are stable while req=1. Dropping req before ack withdraws the request with no side effects.
- The latched operands are the only ALU source. Requester inputs changing after ack have no effect.
- Flags are captured from the same cycle as the results.
- res_* hold their value until the next capture or reset.
- Timeout counter: ceil(log2(TIMEOUT+1)) bits, saturating, cleared on ISSUE and reset.
- Reset mid-operation returns to IDLE immediately with `aluOFF driven. No done is produced for the aborted op.

Decomposition:
- alu.vh: `aluCMDwidth, `aluOFF and command codes (existing, shared).
- New alu_seq.vh: state encodings S_IDLE/S_ISSUE/S_WAIT/S_DONE and the default TIMEOUT.
- One sub-module, rr_arb2: two-input round-robin arbiter with a registered last-grant pointer, inputs req0/req1/advance, outputs grant id/valid.

Test Plan:
- req0: ADD op1=7, op2=13 with the real ALU -> ack0 next cycle; done 3 cycles after ack; res_low=20, done_id=0, err=0, res_zero=0.
- req0 and req1 raised the same cycle out of reset (req1: SUB op1=1, op2=-2):
  - requester 0 is served first, requester 1 after its done.
  - res_low for requester 1 = 3.
  - a third simultaneous pair is served 0 first, 1 second in strict alternation.
- req1: LSH op1=36'o000004_000000, op2=2 -> alu_command stays LSH every cycle while alu_busy=1; done once busy drops; res_low=36'o000020_000000.
- req0: ADD op1=36'o377777_777777, op2=1 -> res_low=36'o400000_000000, res_ovf=1.
- Stub ALU holding alu_busy=1 -> done with err=1 after exactly TIMEOUT cycles in WAIT; alu_command back to `aluOFF.
- reset=0 asserted during WAIT of an LSH -> outputs return to reset values asynchronously; no done pulse; next req0 after release completes normally.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU front-end sequencer:
// command codes, FSM states and timeout sizing.
package alu_seq_pkg;

  localparam int ALU_CMD_W = 5;

  localparam logic [ALU_CMD_W-1:0] ALU_OFF = 5'd0;
  localparam logic [ALU_CMD_W-1:0] ALU_ADD = 5'd1;
  localparam logic [ALU_CMD_W-1:0] ALU_SUB = 5'd2;
  localparam logic [ALU_CMD_W-1:0] ALU_AND = 5'd3;
  localparam logic [ALU_CMD_W-1:0] ALU_LSH = 5'd4;

  localparam int TIMEOUT_DEF = 300;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  function automatic int cnt_w(input int t);
    return $clog2(t + 1);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; the pointer records
// the last granted requester so the other one wins ties.
module rr_arb2 (
  input  logic clk,
  input  logic rst_n,
  input  logic req0,
  input  logic req1,
  input  logic advance,
  output logic gnt_id,
  output logic gnt_vld
);

  logic last;

  // pick the winner: on a tie the one not granted last
  always_comb begin
    gnt_vld = req0 | req1;
    gnt_id  = 1'b0;
    unique case (1'b1)
      (req0 && req1):  gnt_id = ~last;
      (req1 && !req0): gnt_id = 1'b1;
      default:         gnt_id = 1'b0;
    endcase
  end

  // remember who was granted; reset favours requester 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      last <= 1'b1;
    else if (advance && gnt_vld)
      last <= gnt_id;
  end

endmodule

// File: rtl/alu_sequencer.sv
// Two-requester front end for the shared ALU: arbitrate,
// latch, hold the command while busy, return results.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int width   = 36,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req0,
  input  logic [ALU_CMD_W-1:0] cmd0,
  input  logic [width-1:0]     op1high0,
  input  logic [width-1:0]     op1_0,
  input  logic [width-1:0]     op2_0,
  output logic                 ack0,
  input  logic                 req1,
  input  logic [ALU_CMD_W-1:0] cmd1,
  input  logic [width-1:0]     op1high1,
  input  logic [width-1:0]     op1_1,
  input  logic [width-1:0]     op2_1,
  output logic                 ack1,
  output logic                 done,
  output logic                 done_id,
  output logic                 err,
  output logic [width-1:0]     res_high,
  output logic [width-1:0]     res_low,
  output logic                 res_ovf,
  output logic                 res_cry0,
  output logic                 res_cry1,
  output logic                 res_zero,
  output logic [ALU_CMD_W-1:0] alu_command,
  output logic [width-1:0]     alu_op1high,
  output logic [width-1:0]     alu_op1,
  output logic [width-1:0]     alu_op2,
  input  logic [width-1:0]     alu_resulthigh,
  input  logic [width-1:0]     alu_resultlow,
  input  logic                 alu_overflow,
  input  logic                 alu_carry0,
  input  logic                 alu_carry1,
  input  logic                 alu_zero,
  input  logic                 alu_busy
);

  localparam int CW = cnt_w(TIMEOUT);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] SAT   = CW'(TIMEOUT);

  state_e state, nxt;

  logic gnt_id, gnt_vld, arb_adv;
  logic take, capture, abort, drive;
  logic tmo;
  logic [CW-1:0] cnt;

  logic                 l_id;
  logic [ALU_CMD_W-1:0] l_cmd;
  logic [width-1:0]     l_op1h, l_op1, l_op2;

  assign arb_adv = (state == S_IDLE);

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (reset),
    .req0    (req0),
    .req1    (req1),
    .advance (arb_adv),
    .gnt_id  (gnt_id),
    .gnt_vld (gnt_vld)
  );

  // next state and per-cycle strobes
  always_comb begin
    nxt     = state;
    take    = 1'b0;
    capture = 1'b0;
    abort   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (gnt_vld) begin
          take = 1'b1;
          nxt  = S_ISSUE;
        end
      end
      S_ISSUE: nxt = S_WAIT;
      S_WAIT: begin
        if (!alu_busy) begin
          capture = 1'b1;
          nxt     = S_DONE;
        end else if (cnt == LIMIT) begin
          abort = 1'b1;
          nxt   = S_DONE;
        end
      end
      S_DONE:  nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state <= S_IDLE;
    else
      state <= nxt;
  end

  // ALU is fed only from the latches while an op is live
  always_comb begin
    drive       = (state == S_ISSUE) || (state == S_WAIT);
    alu_command = drive ? l_cmd  : ALU_OFF;
    alu_op1high = drive ? l_op1h : '0;
    alu_op1     = drive ? l_op1  : '0;
    alu_op2     = drive ? l_op2  : '0;
  end

  // latch the winner's command and operands
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      l_id   <= 1'b0;
      l_cmd  <= ALU_OFF;
      l_op1h <= '0;
      l_op1  <= '0;
      l_op2  <= '0;
    end else if (take) begin
      l_id   <= gnt_id;
      l_cmd  <= gnt_id ? cmd1     : cmd0;
      l_op1h <= gnt_id ? op1high1 : op1high0;
      l_op1  <= gnt_id ? op1_1    : op1_0;
      l_op2  <= gnt_id ? op2_1    : op2_0;
    end
  end

  // one-cycle accept pulses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
    end else begin
      ack0 <= take && !gnt_id;
      ack1 <= take &&  gnt_id;
    end
  end

  // saturating busy-cycle counter, cleared at issue
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      cnt <= '0;
    else if (state == S_ISSUE)
      cnt <= '0;
    else if (state == S_WAIT && alu_busy && cnt != SAT)
      cnt <= cnt + CW'(1);
  end

  // remembers that the current op was abandoned
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      tmo <= 1'b0;
    else if (take)
      tmo <= 1'b0;
    else if (abort)
      tmo <= 1'b1;
  end

  // results and flags are taken from one cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      res_high <= '0;
      res_low  <= '0;
      res_ovf  <= 1'b0;
      res_cry0 <= 1'b0;
      res_cry1 <= 1'b0;
      res_zero <= 1'b0;
    end else if (capture) begin
      res_high <= alu_resulthigh;
      res_low  <= alu_resultlow;
      res_ovf  <= alu_overflow;
      res_cry0 <= alu_carry0;
      res_cry1 <= alu_carry1;
      res_zero <= alu_zero;
    end else if (abort) begin
      res_high <= '0;
      res_low  <= '0;
      res_ovf  <= 1'b0;
      res_cry0 <= 1'b0;
      res_cry1 <= 1'b0;
      res_zero <= 1'b0;
    end
  end

  // completion pulse with owner and error
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      done    <= 1'b0;
      done_id <= 1'b0;
      err     <= 1'b0;
    end else begin
      done    <= (state == S_DONE);
      done_id <= (state == S_DONE) && l_id;
      err     <= (state == S_DONE) && tmo;
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer with a stub ALU
// and random traffic from both requesters.
module tb_alu_sequencer;
  import alu_seq_pkg::*;

  localparam int W  = 36;
  localparam int TO = TIMEOUT_DEF;
  localparam int ACK_BOUND = 2 * TO + 50;
  localparam logic [ALU_CMD_W-1:0] HANG = '1;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic ovf, c0, c1, z, err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic req0, req1, ack0, ack1;
  logic [ALU_CMD_W-1:0] cmd0, cmd1, alu_command;
  logic [W-1:0] op1high0, op1_0, op2_0;
  logic [W-1:0] op1high1, op1_1, op2_1;
  logic done, done_id, err;
  logic [W-1:0] res_high, res_low;
  logic res_ovf, res_cry0, res_cry1, res_zero;
  logic [W-1:0] alu_op1high, alu_op1, alu_op2;
  logic [W-1:0] alu_resulthigh, alu_resultlow;
  logic alu_overflow, alu_carry0, alu_carry1, alu_zero;
  logic alu_busy;

  int nvec = 0;
  int nerr = 0;
  int cyc = 0;
  int busy_left = 0;
  logic prev_act = 1'b0;
  logic act;

  exp_t q0[$];
  exp_t q1[$];
  int order_q[$];
  logic [ALU_CMD_W-1:0] cur_cmd = ALU_OFF;
  logic [W-1:0] cur_a = '0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  alu_sequencer #(.width(W), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(rst_n),
    .req0(req0), .cmd0(cmd0), .op1high0(op1high0),
    .op1_0(op1_0), .op2_0(op2_0), .ack0(ack0),
    .req1(req1), .cmd1(cmd1), .op1high1(op1high1),
    .op1_1(op1_1), .op2_1(op2_1), .ack1(ack1),
    .done(done), .done_id(done_id), .err(err),
    .res_high(res_high), .res_low(res_low),
    .res_ovf(res_ovf), .res_cry0(res_cry0),
    .res_cry1(res_cry1), .res_zero(res_zero),
    .alu_command(alu_command),
    .alu_op1high(alu_op1high), .alu_op1(alu_op1),
    .alu_op2(alu_op2),
    .alu_resulthigh(alu_resulthigh),
    .alu_resultlow(alu_resultlow),
    .alu_overflow(alu_overflow), .alu_carry0(alu_carry0),
    .alu_carry1(alu_carry1), .alu_zero(alu_zero),
    .alu_busy(alu_busy)
  );

  // PDP-10 style arithmetic: carry0 out of the sign bit,
  // carry1 out of bit 1 into the sign bit
  function automatic exp_t model(input logic [ALU_CMD_W-1:0] c,
                                 input logic [W-1:0] h, a, b);
    exp_t r;
    logic [W:0] s;
    logic [W-1:0] t;
    logic [W-1:0] nb;
    r = '{hi: '0, lo: '0, ovf: 0, c0: 0, c1: 0, z: 0, err: 0};
    nb = ~b;
    if (c == ALU_ADD) begin
      s = {1'b0, a} + {1'b0, b};
      t = {1'b0, a[W-2:0]} + {1'b0, b[W-2:0]};
      r.hi = h; r.lo = s[W-1:0];
      r.c0 = s[W]; r.c1 = t[W-1]; r.ovf = s[W] ^ t[W-1];
    end else if (c == ALU_SUB) begin
      s = {1'b0, a} + {1'b0, nb} + 37'd1;
      t = {1'b0, a[W-2:0]} + {1'b0, nb[W-2:0]} + 36'd1;
      r.hi = h; r.lo = s[W-1:0];
      r.c0 = s[W]; r.c1 = t[W-1]; r.ovf = s[W] ^ t[W-1];
    end else if (c == ALU_AND) begin
      r.hi = h; r.lo = a & b;
    end else if (c == ALU_LSH) begin
      r.lo = (b[7:0] < 8'd36) ? (a << b[7:0]) : '0;
    end
    if (c == HANG) r.err = 1'b1;
    else r.z = (r.lo == '0);
    return r;
  endfunction

  function automatic int stall_of(input logic [ALU_CMD_W-1:0] c,
                                  input logic [W-1:0] b);
    if (c == ALU_LSH) return int'(b[3:0]) + 1;
    if (c == HANG) return 100000;
    return 0;
  endfunction

  function automatic logic [W-1:0] rnd36();
    logic [W-1:0] r;
    r[31:0] = $urandom;
    r[35:32] = 4'($urandom);
    return r;
  endfunction

  // stub ALU: combinational results, busy for a
  // command-dependent number of cycles after issue
  assign act = (alu_command != ALU_OFF);
  assign alu_busy = act && prev_act && (busy_left != 0);

  always_comb begin
    exp_t r;
    r = model(alu_command, alu_op1high, alu_op1, alu_op2);
    alu_resulthigh = r.hi;
    alu_resultlow  = r.lo;
    alu_overflow   = r.ovf;
    alu_carry0     = r.c0;
    alu_carry1     = r.c1;
    alu_zero       = r.z;
    if (alu_command == HANG) begin
      alu_resultlow = 36'o123456_654321;
      alu_overflow  = 1'b1;
      alu_zero      = 1'b1;
    end
  end

  always @(posedge clk) begin
    prev_act <= act;
    if (act && !prev_act)
      busy_left <= stall_of(alu_command, alu_op2);
    else if (alu_busy)
      busy_left <= busy_left - 1;
  end

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] want);
    nvec++;
    if (got !== want) begin
      nerr++;
      $display("FAIL %s: got %0h, required %0h", name, got, want);
    end
  endtask

  // monitor: command hold while busy, scoreboard on done
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (alu_busy) begin
        chk("cmd_hold", {alu_command, alu_op1}, {cur_cmd, cur_a});
      end
      if (done) begin
        order_q.push_back(int'(done_id));
        if ((done_id ? q1.size() : q0.size()) == 0) begin
          nvec++; nerr++;
          $display("FAIL unexpected_done: id=%0d, required none",
                   done_id);
        end else begin
          e = done_id ? q1.pop_front() : q0.pop_front();
          nvec++;
          if (res_low !== e.lo || res_high !== e.hi ||
              res_ovf !== e.ovf || res_cry0 !== e.c0 ||
              res_cry1 !== e.c1 || res_zero !== e.z ||
              err !== e.err) begin
            nerr++;
            $display("FAIL result id=%0d: got lo=%o hi=%o vcc z=%b%b%b %b err=%b, required lo=%o hi=%o vcc z=%b%b%b %b err=%b",
              done_id, res_low, res_high, res_ovf, res_cry0,
              res_cry1, res_zero, err, e.lo, e.hi, e.ovf,
              e.c0, e.c1, e.z, e.err);
          end
        end
      end
    end
  end

  task automatic drive(input int id, input logic r,
                       input logic [ALU_CMD_W-1:0] c,
                       input logic [W-1:0] h, a, b);
    if (id == 0) begin
      req0 = r; cmd0 = c; op1high0 = h; op1_0 = a; op2_0 = b;
    end else begin
      req1 = r; cmd1 = c; op1high1 = h; op1_1 = a; op2_1 = b;
    end
  endtask

  // request, wait for ack, queue the expected result,
  // then scramble the requester's inputs
  task automatic do_req(input int id,
                        input logic [ALU_CMD_W-1:0] c,
                        input logic [W-1:0] h, a, b,
                        output int ack_cyc, output int lat);
    logic got;
    got = 1'b0; ack_cyc = 0; lat = 0;
    drive(id, 1'b1, c, h, a, b);
    for (int k = 1; k <= ACK_BOUND && !got; k++) begin
      @(negedge clk);
      if ((id == 0 && ack0) || (id == 1 && ack1)) begin
        got = 1'b1; lat = k; ack_cyc = cyc;
      end
    end
    if (got) begin
      if (id == 0) q0.push_back(model(c, h, a, b));
      else q1.push_back(model(c, h, a, b));
      cur_cmd = c; cur_a = a;
    end else begin
      nvec++; nerr++;
      $display("FAIL ack_timeout id=%0d: no ack, required within %0d",
               id, ACK_BOUND);
    end
    drive(id, 1'b0, 5'($urandom), rnd36(), rnd36(), rnd36());
  endtask

  task automatic wait_done(input int bound, output int dcyc);
    logic got;
    got = 1'b0; dcyc = 0;
    for (int k = 0; k < bound && !got; k++) begin
      @(negedge clk);
      if (done) begin got = 1'b1; dcyc = cyc; end
    end
    if (!got) begin
      nvec++; nerr++;
      $display("FAIL done_timeout: no done, required within %0d", bound);
    end
  endtask

  task automatic wait_idle(input int bound);
    for (int k = 0; k < bound && (q0.size() + q1.size()) != 0; k++)
      @(negedge clk);
    @(negedge clk);
    chk("drained", 64'(q0.size() + q1.size()), 64'd0);
  endtask

  task automatic rand_traffic(input int id, input int n);
    int ac, lt;
    logic [ALU_CMD_W-1:0] c;
    logic [W-1:0] b;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 4)) @(negedge clk);
      case ($urandom_range(0, 3))
        0: c = ALU_ADD;
        1: c = ALU_SUB;
        2: c = ALU_AND;
        default: c = ALU_LSH;
      endcase
      b = rnd36();
      if (c == ALU_LSH) b = 36'($urandom_range(0, 40));
      do_req(id, c, rnd36(), rnd36(), b, ac, lt);
    end
  endtask

  initial begin
    int ac0, ac1, l0, l1, dc, saw;
    rst_n = 1'b0;
    drive(0, 1'b0, ALU_OFF, '0, '0, '0);
    drive(1, 1'b0, ALU_OFF, '0, '0, '0);
    repeat (3) @(negedge clk);
    chk("rst_cmd", 64'(alu_command), 64'(ALU_OFF));
    chk("rst_op1", 64'(alu_op1), 64'd0);
    chk("rst_done_ack", {done, done_id, err, ack0, ack1}, 64'd0);
    chk("rst_res", 64'(res_low), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // simultaneous pairs from reset: strict alternation
    order_q.delete();
    fork
      do_req(0, ALU_ADD, '0, 36'd5, 36'd6, ac0, l0);
      do_req(1, ALU_SUB, '0, 36'd1, -36'sd2, ac1, l1);
    join
    chk("pair_ack0_lat", 64'(l0), 64'd1);
    wait_idle(50);
    chk("sub_res1", 64'(res_low), 64'd3);
    for (int p = 0; p < 2; p++) begin
      fork
        do_req(0, ALU_AND, rnd36(), rnd36(), rnd36(), ac0, l0);
        do_req(1, ALU_ADD, rnd36(), rnd36(), rnd36(), ac1, l1);
      join
      wait_idle(50);
    end
    chk("order_n", 64'(order_q.size()), 64'd6);
    for (int i = 0; i < order_q.size() && i < 6; i++)
      chk("order", 64'(order_q[i]), 64'(i % 2));

    // ADD 7+13: ack next cycle, done three after
    do_req(0, ALU_ADD, '0, 36'd7, 36'd13, ac0, l0);
    chk("add_ack_lat", 64'(l0), 64'd1);
    wait_done(20, dc);
    chk("add_done_lat", 64'(dc - ac0), 64'd3);
    chk("add_res", 64'(res_low), 64'd20);
    chk("add_id_err_z", {done_id, err, res_zero}, 64'd0);

    // multi-cycle shift held while busy
    do_req(1, ALU_LSH, '0, 36'o000004_000000, 36'd2, ac1, l1);
    wait_done(30, dc);
    chk("lsh_done_lat", 64'(dc - ac1), 64'd6);
    chk("lsh_res", 64'(res_low), 64'(36'o000020_000000));
    chk("lsh_id", 64'(done_id), 64'd1);

    // overflow into the sign bit
    do_req(0, ALU_ADD, '0, 36'o377777_777777, 36'd1, ac0, l0);
    wait_done(20, dc);
    chk("ovf_res", 64'(res_low), 64'(36'o400000_000000));
    chk("ovf_flags", {res_ovf, res_cry0, res_cry1}, 64'b101);

    // ALU never drops busy
    do_req(0, HANG, '0, 36'd1, 36'd1, ac0, l0);
    wait_done(TO + 50, dc);
    chk("tmo_lat", 64'(dc - ac0), 64'(TO + 2));
    chk("tmo_err", 64'(err), 64'd1);
    chk("tmo_res", 64'(res_low), 64'd0);
    chk("tmo_cmd_off", 64'(alu_command), 64'(ALU_OFF));

    // reset in the middle of a long shift
    do_req(0, ALU_LSH, '0, 36'd1, 36'd12, ac0, l0);
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", 64'(alu_busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_cmd", 64'(alu_command), 64'(ALU_OFF));
    chk("mid_rst_out", {done, err, ack0, ack1, alu_op1}, 64'd0);
    chk("mid_rst_res", 64'(res_low), 64'd0);
    q0.delete(); q1.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    saw = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done) saw = 1;
    end
    chk("no_done_abort", 64'(saw), 64'd0);
    do_req(0, ALU_ADD, '0, 36'd100, 36'd23, ac0, l0);
    wait_done(20, dc);
    chk("post_rst_lat", 64'(dc - ac0), 64'd3);
    chk("post_rst_res", 64'(res_low), 64'd123);

    // random traffic from both sides
    fork
      rand_traffic(0, 30);
      rand_traffic(1, 30);
    join
    wait_idle(200);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
